ambulance_request_queue: RTL and testbench

Upstream instruction source for the traffic light controller. Four raw ambulance-detector inputs, one per road, are synchronised and edge-detected, then arbitrated round-robin into a 4-entry in-order queue. Each entry is presented to the controller as a 3-bit interrupt instruction `{1'b1, road}` on a valid/accept handshake. A cooldown counter enforces a minimum spacing between issued interrupts.

---
 rtl/ambulance_request_queue.sv | 165 ++++++++++++++++
 tb/tb_ambulance_request_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ambulance_request_queue.sv
// Ambulance request front end: synchronises four detector inputs, arbitrates new
// requests round-robin into a 4-deep in-order queue and issues them as interrupts.
module ambulance_request_queue #(
    parameter int COOLDOWN = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic             accept,
    output logic             valid,
    output logic [2:0]       instruction,
    output logic [3:0]       pending,
    output logic [CNT_W-1:0] issued_count,
    output logic [7:0]       drop_count
);

    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic [3:0]       s1_r;
    logic [3:0]       s2_r;
    logic [3:0]       s2_d_r;
    logic [3:0]       waiting_r;
    logic [3:0]       queued_r;
    logic [1:0]       rr_r;
    logic [1:0]       fifo_r [0:3];
    logic [1:0]       rd_ptr_r;
    logic [1:0]       wr_ptr_r;
    logic [2:0]       count_r;
    logic [CD_W-1:0]  cooldown_r;
    logic [CNT_W-1:0] issued_r;
    logic [7:0]       drop_r;

    logic [3:0] edge_s;
    logic [3:0] busy_s;
    logic [3:0] new_s;
    logic       dup_s;
    logic       pick_valid_s;
    logic [1:0] pick_idx_s;
    logic [3:0] pick_mask_s;
    logic       valid_s;
    logic       pop_s;
    logic [1:0] head_s;
    logic [3:0] pop_mask_s;

    // Edge detection and duplicate classification against pre-edge state
    always_comb begin
        edge_s = s2_r & ~s2_d_r;
        busy_s = waiting_r | queued_r;
        new_s  = edge_s & ~busy_s;
        dup_s  = |(edge_s & busy_s);
    end

    // Round-robin pick: first waiting road at or above rr, wrapping 3 -> 0
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pick_valid_s && waiting_r[rr_r + 2'(i)]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = rr_r + 2'(i);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
        if (pick_valid_s) begin
            pick_mask_s = 4'b0001 << pick_idx_s;
        end else begin
            pick_mask_s = 4'b0000;
        end
    end

    // Head presentation and pop qualification
    always_comb begin
        head_s  = fifo_r[rd_ptr_r];
        valid_s = (count_r != 3'd0) && (cooldown_r == CD_W'(0));
        pop_s   = accept && valid_s;
        if (pop_s) begin
            pop_mask_s = 4'b0001 << head_s;
        end else begin
            pop_mask_s = 4'b0000;
        end
    end

    assign valid        = valid_s;
    assign instruction  = valid_s ? {1'b1, head_s} : 3'b000;
    assign pending      = waiting_r | queued_r;
    assign issued_count = issued_r;
    assign drop_count   = drop_r;

    // Input synchroniser and edge-history flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r   <= 4'b0000;
            s2_r   <= 4'b0000;
            s2_d_r <= 4'b0000;
        end else begin
            s1_r   <= req;
            s2_r   <= s1_r;
            s2_d_r <= s2_r;
        end
    end

    // Waiting/queued bookkeeping, arbiter pointer and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waiting_r <= 4'b0000;
            queued_r  <= 4'b0000;
            rr_r      <= 2'd0;
            drop_r    <= 8'd0;
        end else begin
            waiting_r <= (waiting_r & ~pick_mask_s) | new_s;
            // A pushed road is never the head being popped, so the masks never overlap
            queued_r  <= (queued_r & ~pop_mask_s) | pick_mask_s;
            if (pick_valid_s) begin
                rr_r <= pick_idx_s + 2'd1;
            end
            if (dup_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    // Queue storage; each road appears at most once, so no full check is needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_r[i] <= 2'd0;
            end
            rd_ptr_r <= 2'd0;
            wr_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (pick_valid_s) begin
                fifo_r[wr_ptr_r] <= pick_idx_s;
                wr_ptr_r         <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({pick_valid_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue spacing and accepted-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cooldown_r <= CD_W'(0);
            issued_r   <= CNT_W'(0);
        end else begin
            if (pop_s) begin
                cooldown_r <= CD_LOAD;
                issued_r   <= issued_r + CNT_W'(1);
            end else if (cooldown_r != CD_W'(0)) begin
                cooldown_r <= cooldown_r - CD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ambulance_request_queue.sv
// Directed bench for ambulance_request_queue with a scoreboard of expected
// instructions in issue order.
module tb_ambulance_request_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        accept;
    logic        valid;
    logic [2:0]  instruction;
    logic [3:0]  pending;
    logic [15:0] issued_count;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;
    int exp_issued = 0;
    int cyc = 0;
    int t1, t2, t3;
    logic [2:0] sb [$];
    logic [2:0] exp_instr;

    ambulance_request_queue #(.COOLDOWN(8), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .accept       (accept),
        .valid        (valid),
        .instruction  (instruction),
        .pending      (pending),
        .issued_count (issued_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for valid, compare head against scoreboard, then pulse accept.
    task automatic do_accept(input string tag, output int seen_cyc);
        int n;
        logic [2:0] e;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        seen_cyc = cyc;
        if (sb.size() > 0) e = sb.pop_front();
        else e = 3'b000;
        chk({tag, "_instr"}, 32'(instruction), 32'(e));
        accept = 1'b1;
        @(negedge clk);
        accept = 1'b0;
        exp_issued++;
        chk({tag, "_issued"}, 32'(issued_count), 32'(exp_issued));
    endtask

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        accept = 1'b0;
        wait_cyc(3);
        chk("rst_valid",   32'(valid),        32'd0);
        chk("rst_instr",   32'(instruction),  32'd0);
        chk("rst_pending", 32'(pending),      32'd0);
        chk("rst_issued",  32'(issued_count), 32'd0);
        chk("rst_drop",    32'(drop_count),   32'd0);
        reset = 1'b0;
        wait_cyc(2);

        // Simultaneous requests from rr=0: order 0,1,3 and 9-cycle issue spacing
        req = 4'b1011;
        sb.push_back(3'b100);
        sb.push_back(3'b101);
        sb.push_back(3'b111);
        do_accept("t2_a", t1);
        do_accept("t2_b", t2);
        do_accept("t2_c", t3);
        chk("t2_gap1", 32'(t2 - t1), 32'd9);
        chk("t2_gap2", 32'(t3 - t2), 32'd9);
        req = 4'b0000;
        wait_cyc(12);
        chk("t2_idle_valid",   32'(valid),   32'd0);
        chk("t2_idle_pending", 32'(pending), 32'd0);

        // Single request latency on road 2
        req = 4'b0100;
        sb.push_back(3'b110);
        wait_cyc(3);
        chk("t1_pend_k2",  32'(pending), 32'b0100);
        chk("t1_valid_k2", 32'(valid),   32'd0);
        wait_cyc(1);
        chk("t1_valid_k3", 32'(valid),       32'd1);
        chk("t1_instr_k3", 32'(instruction), 32'b110);
        do_accept("t1", t1);
        chk("t1_post_valid",   32'(valid),   32'd0);
        chk("t1_post_pending", 32'(pending), 32'd0);
        req = 4'b0000;
        wait_cyc(10);

        // Duplicate edge on a queued road is dropped
        sb.push_back(3'b110);
        req[2] = 1'b1; wait_cyc(2);
        req[2] = 1'b0; wait_cyc(3);
        req[2] = 1'b1; wait_cyc(2);
        req[2] = 1'b0; wait_cyc(4);
        chk("t3_drop",    32'(drop_count), 32'd1);
        chk("t3_pending", 32'(pending),    32'b0100);
        do_accept("t3_a", t1);
        wait_cyc(10);
        sb.push_back(3'b110);
        req[2] = 1'b1; wait_cyc(2);
        req[2] = 1'b0;
        do_accept("t3_b", t1);
        chk("t3_drop_after", 32'(drop_count), 32'd1);
        wait_cyc(10);

        // Round-robin: after road 1, roads 0 and 2 together serve road 2 first
        req = 4'b0010;
        sb.push_back(3'b101);
        wait_cyc(2);
        req = 4'b0000;
        do_accept("t4_r1", t1);
        wait_cyc(10);
        req = 4'b0101;
        sb.push_back(3'b110);
        sb.push_back(3'b100);
        wait_cyc(2);
        req = 4'b0000;
        do_accept("t4_a", t1);
        do_accept("t4_b", t1);
        wait_cyc(10);

        // Spurious accepts while idle are ignored
        for (int i = 0; i < 3; i++) begin
            accept = 1'b1; wait_cyc(1);
            accept = 1'b0; wait_cyc(1);
        end
        chk("t5_spur_issued",  32'(issued_count), 32'(exp_issued));
        chk("t5_spur_pending", 32'(pending),      32'd0);
        chk("t5_spur_valid",   32'(valid),        32'd0);

        // Push of road 0 lands in the same cycle as the pop of road 3
        req = 4'b1000;
        sb.push_back(3'b111);
        wait_cyc(5);
        chk("t5_a_valid", 32'(valid), 32'd1);
        req = 4'b0001;
        sb.push_back(3'b100);
        wait_cyc(3);
        chk("t5_pp_valid", 32'(valid), 32'd1);
        exp_instr = sb.pop_front();
        chk("t5_pp_instr", 32'(instruction), 32'(exp_instr));
        accept = 1'b1;
        wait_cyc(1);
        accept = 1'b0;
        exp_issued++;
        chk("t5_pp_issued",  32'(issued_count), 32'(exp_issued));
        chk("t5_pp_pending", 32'(pending),      32'b0001);
        chk("t5_pp_cool",    32'(valid),        32'd0);
        req = 4'b0000;
        do_accept("t5_b", t1);
        wait_cyc(12);
        chk("t5_end_valid",   32'(valid),   32'd0);
        chk("t5_end_pending", 32'(pending), 32'd0);

        // Reset mid-queue with cooldown running, road 3 held through reset
        req = 4'b1111;
        sb.push_back(3'b101);
        sb.push_back(3'b110);
        sb.push_back(3'b111);
        sb.push_back(3'b100);
        do_accept("t6_a", t1);
        wait_cyc(3);
        chk("t6_pre_pending", 32'(pending), 32'b1101);
        chk("t6_pre_cool",    32'(valid),   32'd0);
        req   = 4'b1000;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid",   32'(valid),        32'd0);
        chk("t6_rst_instr",   32'(instruction),  32'd0);
        chk("t6_rst_pending", 32'(pending),      32'd0);
        chk("t6_rst_issued",  32'(issued_count), 32'd0);
        chk("t6_rst_drop",    32'(drop_count),   32'd0);
        sb.delete();
        exp_issued = 0;
        wait_cyc(2);
        reset = 1'b0;
        sb.push_back(3'b111);
        do_accept("t6_r3", t1);
        wait_cyc(12);
        chk("t6_end_valid",   32'(valid),   32'd0);
        chk("t6_end_pending", 32'(pending), 32'd0);
        chk("t6_end_issued",  32'(issued_count), 32'd1);
        chk("sb_empty",       32'(sb.size()),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
